// File: rtl/ahb_interconnect_n.sv
// ahb_interconnect_n: single-master AHB address decode and response mux with a
// default ERROR slave and a data-phase timeout watchdog.
module ahb_interconnect_n #(
    parameter int                     NSLV     = 8,
    parameter logic [32*NSLV-1:0]     SLV_BASE = {NSLV{32'h0}},
    parameter logic [32*NSLV-1:0]     SLV_MASK = {NSLV{32'hF0000000}},
    parameter int                     TO_CYC   = 255
) (
    input  logic                 HCLK,
    input  logic                 SysRST,
    input  logic [31:0]          HADDR,
    input  logic [1:0]           HTRANS,
    output logic [NSLV-1:0]      HSEL_S,
    input  logic [32*NSLV-1:0]   HRDATA_S,
    input  logic [NSLV-1:0]      HREADYOUT_S,
    input  logic [2*NSLV-1:0]    HRESP_S,
    output logic                 HREADY,
    output logic [1:0]           HRESP,
    output logic [31:0]          HRDATA,
    input  logic                 TIMEOUT_CLR,
    output logic                 TIMEOUT_IRQ,
    output logic [3:0]           TO_SLV
);
    typedef enum logic [1:0] {IDLE, SLAVE, ERR1, ERR2} state_t;
    localparam logic [7:0] TO_LIM = 8'(TO_CYC);
    state_t      state_q, state_d;
    logic [3:0]  dsel_q, dsel_d, to_slv_q, to_slv_d, hit_idx;
    logic [7:0]  cnt_q, cnt_d;
    logic        irq_q, irq_d, hit, s_rdy, ready;
    logic [1:0]  s_resp, resp;
    logic [31:0] s_data, data;
    logic        unused_htrans0;
    assign unused_htrans0 = HTRANS[0];
    // First match wins, so overlapping regions resolve to the lowest index.
    always_comb begin
        HSEL_S = '0;
        hit = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NSLV; i++)
            if (!hit && (HADDR & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                HSEL_S[i] = 1'b1;
                hit_idx = 4'(i);
                hit = 1'b1;
            end
    end
    always_comb begin
        s_rdy = 1'b1;
        s_resp = '0;
        s_data = '0;
        for (int i = 0; i < NSLV; i++)
            if (dsel_q == 4'(i)) begin
                s_rdy = HREADYOUT_S[i];
                s_resp = HRESP_S[2*i +: 2];
                s_data = HRDATA_S[32*i +: 32];
            end
    end
    always_comb begin
        state_d = state_q;
        dsel_d = dsel_q;
        cnt_d = cnt_q;
        irq_d = TIMEOUT_CLR ? 1'b0 : irq_q;
        to_slv_d = to_slv_q;
        ready = 1'b1;
        resp = 2'b00;
        data = '0;
        case (state_q)
            SLAVE: begin
                ready = s_rdy;
                resp = s_resp;
                data = s_data;
                if (!s_rdy) begin
                    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                    if (TO_LIM != 8'd0 && cnt_d == TO_LIM) begin
                        state_d = ERR1;
                        irq_d = 1'b1;
                        to_slv_d = dsel_q;
                    end
                end
            end
            ERR1: begin
                ready = 1'b0;
                resp = 2'b01;
                state_d = ERR2;
            end
            ERR2: resp = 2'b01;
            default: ;
        endcase
        // Any completing data phase doubles as the next address phase.
        if (ready) begin
            state_d = !HTRANS[1] ? IDLE : hit ? SLAVE : ERR1;
            if (HTRANS[1] && hit) begin
                dsel_d = hit_idx;
                cnt_d = '0;
            end
        end
    end
    always_ff @(posedge HCLK or posedge SysRST) begin
        if (SysRST) begin
            state_q <= IDLE;
            dsel_q <= '0;
            cnt_q <= '0;
            irq_q <= 1'b0;
            to_slv_q <= '0;
        end else begin
            state_q <= state_d;
            dsel_q <= dsel_d;
            cnt_q <= cnt_d;
            irq_q <= irq_d;
            to_slv_q <= to_slv_d;
        end
    end
    assign HREADY = ready;
    assign HRESP = resp;
    assign HRDATA = data;
    assign TIMEOUT_IRQ = irq_q;
    assign TO_SLV = to_slv_q;
endmodule

// File: tb/tb_ahb_interconnect_n.sv
// tb_ahb_interconnect_n: directed vectors with hand-computed expectations.
module tb_ahb_interconnect_n;
    localparam int NSLV = 8;
    localparam logic [32*NSLV-1:0] BASE = {32'h70000000, 32'h60000000, 32'h50000000, 32'h40000000,
                                           32'h30000000, 32'h20000000, 32'h10000000, 32'h10000000};
    localparam logic [32*NSLV-1:0] MASK = {{7{32'hF0000000}}, 32'hFF000000};
    logic                 clk = 1'b0, rst = 1'b1;
    logic [31:0]          haddr = '0;
    logic [1:0]           htrans = '0;
    logic [NSLV-1:0]      hsel;
    logic [32*NSLV-1:0]   hrdata_s = '0;
    logic [NSLV-1:0]      hreadyout_s = '1;
    logic [2*NSLV-1:0]    hresp_s = '0;
    logic                 hready, to_clr = 1'b0, to_irq;
    logic [1:0]           hresp;
    logic [31:0]          hrdata;
    logic [3:0]           to_slv;
    int checks = 0, failures = 0;

    ahb_interconnect_n #(.NSLV(NSLV), .SLV_BASE(BASE), .SLV_MASK(MASK), .TO_CYC(4)) dut (
        .HCLK(clk), .SysRST(rst), .HADDR(haddr), .HTRANS(htrans), .HSEL_S(hsel),
        .HRDATA_S(hrdata_s), .HREADYOUT_S(hreadyout_s), .HRESP_S(hresp_s),
        .HREADY(hready), .HRESP(hresp), .HRDATA(hrdata),
        .TIMEOUT_CLR(to_clr), .TIMEOUT_IRQ(to_irq), .TO_SLV(to_slv)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lows;
        for (int i = 0; i < NSLV; i++) hrdata_s[32*i +: 32] = 32'hA0A00000 | i;
        haddr = 32'h70000010;
        #1;
        check("hsel_in_reset", 32'(hsel), 32'h80);
        check("rst_hready", 32'(hready), 1);
        check("rst_hresp", 32'(hresp), 0);
        check("rst_hrdata", hrdata, 0);
        check("rst_irq", 32'(to_irq), 0);
        check("rst_to_slv", 32'(to_slv), 0);
        tick();
        rst = 1'b0;
        tick();
        // Slave 7 read with two wait states
        htrans = 2'b10;
        hreadyout_s[7] = 1'b0;
        hrdata_s[32*7 +: 32] = 32'hDEADBEEF;
        #1;
        check("s7_hsel", 32'(hsel), 32'h80);
        tick();
        htrans = 2'b00;
        #1;
        check("s7_wait1", 32'(hready), 0);
        tick();
        check("s7_wait2", 32'(hready), 0);
        tick();
        hreadyout_s[7] = 1'b1;
        #1;
        check("s7_ready", 32'(hready), 1);
        check("s7_data", hrdata, 32'hDEADBEEF);
        check("s7_resp", 32'(hresp), 0);
        tick();
        check("idle_data", hrdata, 0);
        // Unmapped address goes to the default slave
        haddr = 32'hF0000000;
        htrans = 2'b10;
        #1;
        check("unmapped_hsel", 32'(hsel), 0);
        tick();
        htrans = 2'b00;
        #1;
        check("err1_hready", 32'(hready), 0);
        check("err1_hresp", 32'(hresp), 1);
        check("err1_hsel", 32'(hsel), 0);
        tick();
        check("err2_hready", 32'(hready), 1);
        check("err2_hresp", 32'(hresp), 1);
        tick();
        check("post_err_hresp", 32'(hresp), 0);
        // Pipelined slave0 then slave3, zero-wait
        haddr = 32'h10000000;
        htrans = 2'b10;
        tick();
        haddr = 32'h30000000;
        #1;
        check("pipe_hsel3", 32'(hsel), 32'h08);
        check("pipe_data0", hrdata, 32'hA0A00000);
        check("pipe_rdy0", 32'(hready), 1);
        tick();
        htrans = 2'b00;
        #1;
        check("pipe_data3", hrdata, 32'hA0A00003);
        tick();
        // Slave 2 stalls forever -> watchdog
        haddr = 32'h20000000;
        htrans = 2'b10;
        hreadyout_s[2] = 1'b0;
        tick();
        htrans = 2'b00;
        #1;
        lows = 0;
        while (!hready && lows < 20) begin
            lows++;
            tick();
        end
        check("to_low_cycles", 32'(lows), 5);
        check("to_hresp", 32'(hresp), 1);
        check("to_irq", 32'(to_irq), 1);
        check("to_slv", 32'(to_slv), 2);
        tick();
        hreadyout_s[2] = 1'b1;
        #1;
        check("to_late_ignored", 32'(hready), 1);
        check("to_late_data", hrdata, 0);
        check("irq_sticky", 32'(to_irq), 1);
        to_clr = 1'b1;
        tick();
        to_clr = 1'b0;
        #1;
        check("irq_cleared", 32'(to_irq), 0);
        check("to_slv_held", 32'(to_slv), 2);
        // Overlap: regions 0 and 1 both match
        haddr = 32'h10000000;
        #1;
        check("overlap_hsel", 32'(hsel), 32'h01);
        haddr = 32'h11000000;
        #1;
        check("slave1_hsel", 32'(hsel), 32'h02);
        // Reset during a slave-1 wait state
        htrans = 2'b10;
        hreadyout_s[1] = 1'b0;
        hresp_s[3:2] = 2'b01;
        tick();
        htrans = 2'b00;
        #1;
        check("s1_wait", 32'(hready), 0);
        check("s1_err_pass", 32'(hresp), 1);
        check("s1_data_pass", hrdata, 32'hA0A00001);
        #2;
        rst = 1'b1;
        #1;
        check("arst_hready", 32'(hready), 1);
        check("arst_hresp", 32'(hresp), 0);
        check("arst_hrdata", hrdata, 0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_idle", 32'(hready), 1);
        tick();
        check("post_rst_idle2", 32'(hready), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ahb_interconnect_n.md
# ahb_interconnect_n

Parametrised single-master AHB slave-side interconnect. It merges address decode (`ahb_decoder`) and response multiplexing (`ahb_mux_s2m`) into one block with a configurable slave count and per-slave base/mask regions. It adds a built-in default slave that returns a two-cycle ERROR, and a data-phase timeout watchdog. It sits between the CPU AHB master port and all AHB slaves (ROM, OCRAM, CREGS, peripheral bridge, SRAM controllers).

## Interface

Parameters:
- `NSLV`, 8: number of slaves, 1..16.
- `SLV_BASE`, {NSLV{32'h0}}: packed bases, slave i at `[32*i+31:32*i]`.
- `SLV_MASK`, {NSLV{32'hF0000000}}: packed masks, same packing.
- `TO_CYC`, 255: wait-state limit before forced ERROR, 8-bit; 0 disables the watchdog.

Ports:
- `HCLK` in 1: system clock. One clock domain.
- `SysRST` in 1: reset, asynchronous, active-high.
- `HADDR` in 32: master address.
- `HTRANS` in 2: master transfer type.
- `HSEL_S` out NSLV: one-hot address-phase slave select.
- `HRDATA_S` in 32*NSLV: packed slave read data.
- `HREADYOUT_S` in NSLV: slave ready outputs.
- `HRESP_S` in 2*NSLV: packed slave responses (00 OKAY, 01 ERROR).
- `HREADY` out 1: ready to master; also broadcast to all slaves as HREADY in.
- `HRESP` out 2: response to master.
- `HRDATA` out 32: read data to master.
- `TIMEOUT_CLR` in 1: clears the timeout flag.
- `TIMEOUT_IRQ` out 1: sticky timeout flag.
- `TO_SLV` out 4: index of the slave that timed out.

## Operation

- Decode (combinational):
  - hit_i = ((HADDR & MASK_i) == BASE_i).
  - On overlapping regions the lowest index wins, so `HSEL_S` is strictly one-hot or zero.
  - `HSEL_S` is driven regardless of HTRANS; slaves qualify it with HTRANS.
- Data-phase capture happens on the HCLK edge with `HREADY`=1:
  - HTRANS[1]=1 and a hit: state SLAVE, dsel <= hit index, wait counter <= 0.
  - HTRANS[1]=1 and no hit: state ERR1 (default slave).
  - HTRANS[1]=0 (IDLE/BUSY): state IDLE.
- FSM states: IDLE, SLAVE, ERR1, ERR2.
  - IDLE drives HREADY=1, HRESP=00, HRDATA=0.
  - SLAVE passes HREADYOUT_S, HRESP_S and HRDATA_S of slave dsel straight through.
    - On HREADYOUT_S[dsel]=1, a new capture occurs.
    - With HREADYOUT_S[dsel]=0 the counter increments.
    - When the counter reaches TO_CYC (TO_CYC≠0), go to ERR1, set TIMEOUT_IRQ, and load TO_SLV<=dsel.
  - ERR1 drives HREADY=0, HRESP=01, HRDATA=0, then moves to ERR2 unconditionally.
  - ERR2 drives HREADY=1, HRESP=01, HRDATA=0. A new capture occurs on this edge (the master may have already issued the next address).
- Slave ERROR responses pass through unchanged; the interconnect does not re-time them.
- Timeout flag:
  - TIMEOUT_CLR=1 clears TIMEOUT_IRQ.
  - A timeout in the same cycle as the clear wins, so the flag stays set.
  - TO_SLV holds the last timed-out index.
- After a timeout the slave's late HREADYOUT is ignored. That slave is not re-selected until the master issues a new address to it.

## Timing

- Reset values: state IDLE, dsel=0, counter=0, HREADY=1, HRESP=00, HRDATA=0, TIMEOUT_IRQ=0, TO_SLV=0. `HSEL_S` follows HADDR combinationally, even during reset.
- Mid-transfer reset forces IDLE asynchronously; the outputs take their reset values in the same cycle.
- Response path is zero-latency combinational (slave → master); no added wait states on hits.
- Default-slave response is exactly 2 cycles (1 wait + 1 ERROR completion).
- Timeout: with the slave stalled, HREADY is low for TO_CYC cycles in SLAVE plus 1 cycle in ERR1, then completes in ERR2.
- Counter width is 8 bits and saturates; it never wraps.

## Test plan

- NSLV=8, region7 base 0x70000000 mask 0xF0000000. NONSEQ read 0x70000010; slave7 returns 0xDEADBEEF with 2 wait states → HSEL_S=0x80 in the address phase; master sees HREADY low 2 cycles, then HRDATA=0xDEADBEEF, HRESP=00.
- NONSEQ to an unmapped address 0xF0000000 → HSEL_S=0; next cycle HREADY=0/HRESP=01, then HREADY=1/HRESP=01; no slave ever selected.
- Back-to-back pipelined NONSEQ to slave0 then slave3, both zero-wait → data phases return slave0 data then slave3 data in consecutive cycles.
- TO_CYC=4, slave2 holds HREADYOUT=0 indefinitely → HREADY low 5 cycles, ERROR completes on the 6th, TIMEOUT_IRQ=1, TO_SLV=2; TIMEOUT_CLR pulse → IRQ=0.
- Overlapping regions 0 and 1 both matching 0x10000000 → only HSEL_S[0]=1.
- Assert SysRST during a slave-1 wait state → HREADY=1, HRESP=00, HRDATA=0 immediately; after release an IDLE transfer leaves HREADY=1.
